// File: rtl/regbank_write_queue_if.sv
// rtl/regbank_write_queue_if.sv - writeback request, bank write port and forwarding lookup bundle
interface regbank_write_queue_if #(
    parameter int ADDRESS_SIZE  = 5,
    parameter int REGISTER_SIZE = 8,
    parameter int DEPTH         = 4
);
    logic                       req_valid;
    logic                       req_ready;
    logic [ADDRESS_SIZE-1:0]    req_addr;
    logic [REGISTER_SIZE-1:0]   req_data;

    logic                       wr_grant;
    logic                       write;
    logic [ADDRESS_SIZE-1:0]    addr_in;
    logic [REGISTER_SIZE-1:0]   data_in;

    logic [ADDRESS_SIZE-1:0]    lookup_addr;
    logic                       lookup_hit;
    logic [REGISTER_SIZE-1:0]   lookup_data;

    logic [$clog2(DEPTH):0]     count;

    // master: pipeline + bank side driving the queue
    modport master (
        output req_valid, req_addr, req_data, wr_grant, lookup_addr,
        input  req_ready, write, addr_in, data_in, lookup_hit, lookup_data, count
    );

    modport slave (
        input  req_valid, req_addr, req_data, wr_grant, lookup_addr,
        output req_ready, write, addr_in, data_in, lookup_hit, lookup_data, count
    );
endinterface

// File: rtl/regbank_write_queue.sv
// rtl/regbank_write_queue.sv - in-order writeback FIFO feeding Register_bank with pending-value forwarding
module regbank_write_queue #(
    parameter int ADDRESS_SIZE  = 5,
    parameter int REGISTER_SIZE = 8,
    parameter int DEPTH         = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    regbank_write_queue_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [ADDRESS_SIZE-1:0]    addr_q [DEPTH];
    logic [REGISTER_SIZE-1:0]   data_q [DEPTH];
    logic [DEPTH-1:0]           valid_q;
    logic [PTR_W-1:0]           head_q;
    logic [PTR_W-1:0]           tail_q;
    logic [CNT_W-1:0]           count_q;

    logic                       not_empty;
    logic                       push_fire;
    logic                       push_en;
    logic                       pop_en;
    logic [PTR_W-1:0]           scan_idx;

    assign not_empty     = (count_q != '0);
    assign bus.req_ready = (count_q != FULL_COUNT);
    assign bus.write     = not_empty;
    assign bus.count     = count_q;

    // Register 0 is hard-wired in the bank: complete the handshake but drop the entry.
    assign push_fire = bus.req_valid && bus.req_ready;
    assign push_en   = push_fire && (bus.req_addr != '0);
    assign pop_en    = not_empty && bus.wr_grant;

    assign bus.addr_in = not_empty ? addr_q[head_q] : '0;
    assign bus.data_in = not_empty ? data_q[head_q] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            // push and pop never share an index: that needs count 0 and DEPTH at once
            if (push_en) begin
                addr_q[tail_q]  <= bus.req_addr;
                data_q[tail_q]  <= bus.req_data;
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            if (pop_en) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            case ({push_en, pop_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        bus.lookup_hit  = 1'b0;
        bus.lookup_data = '0;
        scan_idx        = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PTR_W'(i);
            if (valid_q[scan_idx] && (bus.lookup_addr != '0) &&
                (addr_q[scan_idx] == bus.lookup_addr)) begin
                bus.lookup_hit  = 1'b1;
                bus.lookup_data = data_q[scan_idx];
            end
        end
    end
endmodule

// File: tb/tb_regbank_write_queue.sv
// tb/tb_regbank_write_queue.sv - directed self-checking bench for regbank_write_queue
module tb_regbank_write_queue;
    logic clk;
    logic reset;
    int   vectors;
    int   errs;

    regbank_write_queue_if #(.ADDRESS_SIZE(5), .REGISTER_SIZE(8), .DEPTH(4)) bus ();

    regbank_write_queue #(.ADDRESS_SIZE(5), .REGISTER_SIZE(8), .DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [7:0] d);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        vectors = 0;
        errs    = 0;
        reset           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_addr    = '0;
        bus.req_data    = '0;
        bus.wr_grant    = 1'b0;
        bus.lookup_addr = '0;
        tick();
        tick();

        chk("rst_write", bus.write, 0);
        chk("rst_ready", bus.req_ready, 1);
        chk("rst_hit", bus.lookup_hit, 0);
        chk("rst_count", bus.count, 0);
        chk("rst_addr_in", bus.addr_in, 0);
        chk("rst_data_in", bus.data_in, 0);
        chk("rst_lookup_data", bus.lookup_data, 0);
        reset = 1'b1;
        tick();

        // single push with grant held high
        bus.wr_grant = 1'b1;
        bus.lookup_addr = 5'd3;
        push(5'd3, 8'h5A);
        chk("single_write", bus.write, 1);
        chk("single_addr", bus.addr_in, 3);
        chk("single_data", bus.data_in, 8'h5A);
        chk("single_count", bus.count, 1);
        chk("single_fwd_hit", bus.lookup_hit, 1);
        chk("single_fwd_data", bus.lookup_data, 8'h5A);
        tick();
        chk("single_done_write", bus.write, 0);
        chk("single_done_count", bus.count, 0);
        chk("single_done_hit", bus.lookup_hit, 0);

        // fill with no grant, then drain in order
        bus.wr_grant = 1'b0;
        for (int i = 1; i <= 4; i++) push(5'(i), 8'(i * 8'h11));
        chk("full_count", bus.count, 4);
        chk("full_ready", bus.req_ready, 0);
        chk("full_hold_addr", bus.addr_in, 1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd5;
        bus.req_data  = 8'h55;
        tick();
        bus.req_valid = 1'b0;
        chk("fifth_rejected_count", bus.count, 4);
        chk("fifth_hold_write", bus.write, 1);
        chk("fifth_hold_data", bus.data_in, 8'h11);
        bus.wr_grant = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_addr", bus.addr_in, 32'(i));
            chk("drain_data", bus.data_in, 32'(i * 8'h11));
            tick();
            chk("drain_count", bus.count, 32'(4 - i));
            chk("drain_ready", bus.req_ready, 1);
        end
        chk("drain_idle", bus.write, 0);

        // forwarding of the youngest pending value
        bus.wr_grant = 1'b0;
        push(5'd7, 8'h10);
        push(5'd7, 8'h20);
        bus.lookup_addr = 5'd7;
        #1;
        chk("fwd_hit", bus.lookup_hit, 1);
        chk("fwd_youngest", bus.lookup_data, 8'h20);
        chk("fwd_head_data", bus.data_in, 8'h10);
        bus.lookup_addr = 5'd6;
        #1;
        chk("fwd_miss", bus.lookup_hit, 0);
        bus.lookup_addr = 5'd7;
        bus.wr_grant = 1'b1;
        tick();
        chk("fwd_second_data", bus.data_in, 8'h20);
        chk("fwd_still_hit", bus.lookup_hit, 1);
        tick();
        chk("fwd_drained_hit", bus.lookup_hit, 0);
        chk("fwd_drained_count", bus.count, 0);

        // address 0 is handshaken but dropped
        bus.wr_grant = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd0;
        bus.req_data  = 8'hFF;
        #1;
        chk("a0_ready", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        bus.lookup_addr = 5'd0;
        #1;
        chk("a0_count", bus.count, 0);
        chk("a0_write", bus.write, 0);
        chk("a0_hit", bus.lookup_hit, 0);

        // full queue, then concurrent push/pop across pointer wrap
        for (int i = 0; i < 4; i++) push(5'(8 + i), 8'(8'hA0 + i));
        bus.wr_grant = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.req_valid = (k <= 4);
            bus.req_addr  = (k == 0) ? 5'd12 : 5'(11 + k);
            bus.req_data  = (k == 0) ? 8'hA4 : 8'(8'hA3 + k);
            #1;
            chk("pp_ready", bus.req_ready, (k == 0) ? 0 : 1);
            chk("pp_addr", bus.addr_in, 32'(8 + k));
            chk("pp_data", bus.data_in, 32'(8'hA0 + k));
            tick();
            chk("pp_count", bus.count, (k <= 4) ? 3 : 32'(7 - k));
        end
        bus.req_valid = 1'b0;
        chk("pp_idle", bus.write, 0);

        // reset while entries are pending
        bus.wr_grant = 1'b0;
        push(5'd1, 8'h01);
        push(5'd2, 8'h02);
        push(5'd3, 8'h03);
        chk("mid_count", bus.count, 3);
        chk("mid_write", bus.write, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_write", bus.write, 0);
        chk("mid_rst_count", bus.count, 0);
        chk("mid_rst_addr", bus.addr_in, 0);
        bus.req_valid = 1'b1;
        bus.req_addr  = 5'd9;
        bus.req_data  = 8'h99;
        tick();
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.wr_grant = 1'b1;
        #1;
        chk("post_rst_count", bus.count, 0);
        tick();
        chk("post_rst_write", bus.write, 0);
        chk("post_rst_addr", bus.addr_in, 0);
        chk("post_rst_data", bus.data_in, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/regbank_write_queue.md
Name: regbank_write_queue

Overview:
- Write-side front end for Register_bank: collects register writeback requests from the pipeline over a valid/ready handshake and buffers them in an in-order FIFO.
- Drains the FIFO onto the bank's single write port (write/addr_in/data_in) whenever the port is granted.
- Provides a forwarding lookup so readers see pending (not yet committed) values.
- Sits between the execute/memory writeback stage and Register_bank.

Parameters:
- ADDRESS_SIZE, 5, register address width; must match Register_bank.
- REGISTER_SIZE, 8, register data width; must match Register_bank.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  writeback request present.
- req_ready  out  1  queue can accept a request this cycle.
- req_addr  in  ADDRESS_SIZE  destination register.
- req_data  in  REGISTER_SIZE  value to write.
- wr_grant  in  1  bank write port available this cycle.
- write  out  1  write enable to Register_bank.
- addr_in  out  ADDRESS_SIZE  write address to Register_bank.
- data_in  out  REGISTER_SIZE  write data to Register_bank.
- lookup_addr  in  ADDRESS_SIZE  register being read by a consumer.
- lookup_hit  out  1  a pending entry targets lookup_addr.
- lookup_data  out  REGISTER_SIZE  data of the youngest matching pending entry.
- count  out  log2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (reset=0, asynchronous):
  - head/tail pointers and count cleared; all entries invalidated.
  - Outputs: write=0, req_ready=1, lookup_hit=0, count=0.
  - addr_in, data_in and lookup_data are 0 during reset.
- Reset mid-operation: every pending entry is discarded and never written to the bank. Deassertion is synchronised by the first clock edge; no request is accepted on the edge at which reset is still low.
- Push:
  - Occurs on the edge where req_valid && req_ready.
  - Entry {req_addr, req_data} is stored at the tail; tail increments modulo DEPTH.
  - req_ready = (count != DEPTH), combinational from state only. There is no pass-through when full, even if a pop happens the same cycle.
- Address-0 requests:
  - Handshaken normally (consume req_ready) but not enqueued: count is unchanged.
  - Never cause a write and never produce a lookup hit. Register 0 is never written by this block.
- Drain:
  - write = (count != 0); addr_in/data_in are driven combinationally from the head entry.
  - Pop on the edge where write && wr_grant; head increments modulo DEPTH.
  - If wr_grant=0, the head is held and write stays asserted with stable addr_in/data_in until granted.
- Latency: a request accepted at edge N appears on write/addr_in/data_in after edge N and is committed by the bank at edge N+1 if wr_grant=1. Sustained throughput is 1 write/cycle.
- Simultaneous push and pop (not full): count unchanged, both pointers advance. Empty + push + no pop → count 1.
- Ordering:
  - Strict FIFO.
  - Two pending writes to the same register are both issued, oldest first; the final bank value is the younger one.
- Lookup (combinational):
  - Scans valid entries; a hit selects the youngest entry (closest to tail) whose address equals lookup_addr.
  - lookup_addr=0 never hits.
  - The head entry being popped this cycle still counts as a hit, since the bank has not yet committed it.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally; full/empty are distinguished by count, not pointer equality.
- count is never greater than DEPTH. No overflow or underflow is possible by construction: push only when ready, pop only when non-empty.

Test Plan:
- Reset then single push: addr=3, data=0x5A, wr_grant=1 → next cycle write=1, addr_in=3, data_in=0x5A; following cycle write=0, count=0.
- Fill with wr_grant=0: push addr 1..4, data 0x11..0x44 → count=4, req_ready=0. A 5th request is not accepted. Raise wr_grant → writes issue in order 1,2,3,4 on consecutive cycles; req_ready rises after the first pop.
- Forwarding: with wr_grant=0, push (7,0x10) then (7,0x20); lookup_addr=7 → hit=1, data=0x20. lookup_addr=6 → hit=0. After both drain → hit=0.
- Address 0: push (0,0xFF) → req_ready handshake completes, count stays 0, write never asserts, lookup_addr=0 → hit=0.
- Simultaneous push/pop: with count=4 (DEPTH=4), wr_grant=1 and req_valid=1 → no push that cycle, count 3. Next cycle push+pop → count stays 3; pointers wrap past index 3 correctly (data order preserved across 8 sequential writes).
- Reset mid-drain: with count=3, assert reset for 1 cycle → write=0 immediately, count=0; after release, no stale write appears on addr_in/data_in.
